func_edge_monitor: RTL
======================

FUNC_EDGE_MONITOR -- requirements
Module: func_edge_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the rising-edge counter (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  qualifies in_bit this cycle.
REQ-005 SHALL have port in_bit  input  1  Out of the upstream selectable-function stage.
REQ-006 SHALL have port clr  input  1  synchronous clear of counter, history and FSM.
REQ-007 SHALL have port rise  output  1  one-cycle pulse, 0->1 transition between consecutive valid samples.
REQ-008 SHALL have port fall  output  1  one-cycle pulse, 1->0 transition between consecutive valid samples.
REQ-009 SHALL have port edge_cnt  output  CNT_W  count of rise events.
REQ-010 SHALL have port cnt_ovf  output  1  sticky counter-overflow flag.
REQ-011 SHALL have port match  output  1  one-cycle pulse, valid-sample sequence 1,0,1,1 detected.

Function
REQ-012 SHALL keep last_sample and primed flag; first valid sample after reset/clr only primes and produces no rise/fall.
REQ-013 SHALL, for valid sample s with primed history l, assert rise (l=0,s=1) or fall (l=1,s=0) in the following cycle, all outputs registered, latency 1.
REQ-014 SHALL hold all state and drive rise, fall, match to 0 in cycles after in_valid=0; invalid cycles never break a sequence.
REQ-015 SHALL increment edge_cnt in the same cycle rise is asserted.
REQ-016 SHALL implement FSM S_IDLE, S_1, S_10, S_101, advancing only on valid samples.
REQ-017 SHALL transition: S_IDLE 1->S_1, 0->S_IDLE; S_1 1->S_1, 0->S_10; S_10 1->S_101, 0->S_IDLE; S_101 1->S_1 with match, 0->S_10 (overlapping detection).
REQ-018 SHALL assert match the cycle after the completing sample; FSM counts the first sample after reset/clr.
REQ-019 SHALL give clr priority over a simultaneous in_valid: sample discarded, next cycle all outputs 0, FSM S_IDLE, primed=0, cnt_ovf cleared.
REQ-020 SHALL keep edge_cnt unsigned, CNT_W bits; overflow behaviour per Configuration.

Reset
REQ-021 SHALL on rst=1, immediately and independent of clk, force rise=0, fall=0, match=0, edge_cnt=0, cnt_ovf=0, FSM S_IDLE, primed=0, last_sample=0.
REQ-022 SHALL abandon any partial sequence on reset mid-operation; first valid sample after rst release is treated as first after clr.

Configuration
REQ-023 SHALL use macro FUNC_MON_SAT_EN.
REQ-024 SHALL, with FUNC_MON_SAT_EN defined, saturate edge_cnt at 2^CNT_W-1; a rise at max holds the count and sets cnt_ovf.
REQ-025 SHALL, without FUNC_MON_SAT_EN, wrap edge_cnt from 2^CNT_W-1 to 0 and set cnt_ovf on the wrap.
REQ-026 SHALL, in both builds, keep cnt_ovf set until rst or clr.

Structure
REQ-027 SHALL place FSM state encoding (2-bit localparams S_IDLE=0, S_1=1, S_10=2, S_101=3) and default CNT_W in shared package func_pkg, also used by the bench.
REQ-028 SHALL split the pattern FSM into one sub-module func_seq_det (inputs clk, rst, clr, in_valid, in_bit; output match); edge logic and counter stay in the top.

Verification
REQ-029 SHALL cover: reset, valid samples 0,1,0,1 -> rise at cycles 2 and 4 after first sample, fall at 3, edge_cnt=2, no rise for the first sample.
REQ-030 SHALL cover: valid samples 1,0,1,1,0,1,1 -> match exactly twice, the cycle after the 4th and 7th samples (overlap).
REQ-031 SHALL cover: samples 1,0 then in_valid=0 for 5 cycles then 1,1 -> single match, outputs 0 during gap.
REQ-032 SHALL cover: CNT_W=2, 5 rise events -> SAT build edge_cnt=3, cnt_ovf=1 after 4th rise; wrap build edge_cnt=1, cnt_ovf=1 after 4th rise.
REQ-033 SHALL cover: clr asserted with in_valid=1,in_bit=1 while FSM in S_101 -> no match, edge_cnt=0, next sample 1 yields no rise.
REQ-034 SHALL cover: rst pulsed between clk edges mid-sequence (after 1,0,1) -> outputs 0 before next edge; subsequent 1 gives no match.

Source files
------------

// File: rtl/func_pkg.sv
// func_pkg: shared FSM state encoding and default counter width for the edge monitor
package func_pkg;
  localparam int CNT_W_DEF = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_1    = 2'd1;
  localparam logic [1:0] S_10   = 2'd2;
  localparam logic [1:0] S_101  = 2'd3;
endpackage

// File: rtl/func_edge_monitor_seq_det.sv
// func_seq_det: overlapping 1,0,1,1 detector over valid samples, registered match pulse
module func_seq_det
  import func_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_valid,
  input  logic in_bit,
  output logic match
);
  logic [1:0] state;
  logic [1:0] nxt;
  assign nxt = in_bit ? (state == S_10 ? S_101 : S_1)
                      : ((state == S_1 || state == S_101) ? S_10 : S_IDLE);
  // advance only on valid samples; clr discards the sample and restarts the search
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      match <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE;
      match <= 1'b0;
    end else begin
      match <= in_valid && state == S_101 && in_bit;
      if (in_valid) state <= nxt;
    end
endmodule

// File: rtl/func_edge_monitor.sv
// func_edge_monitor: rise/fall pulses, rise counter with sticky overflow, 1011 match; FUNC_MON_SAT_EN selects saturating counter
module func_edge_monitor
  import func_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_ovf,
  output logic             match
);
  logic last;
  logic primed;
  logic rise_d;
  logic fall_d;
  logic at_max;
  assign rise_d = in_valid & primed & ~last & in_bit;
  assign fall_d = in_valid & primed & last & ~in_bit;
  assign at_max = edge_cnt == {CNT_W{1'b1}};
  // sample history, edge pulses and rise counter; first valid sample only primes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last     <= 1'b0;
      primed   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (clr) begin
      last     <= 1'b0;
      primed   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else begin
      rise <= rise_d;
      fall <= fall_d;
      if (in_valid) begin
        last   <= in_bit;
        primed <= 1'b1;
      end
      if (rise_d) begin
        cnt_ovf <= cnt_ovf | at_max;
`ifdef FUNC_MON_SAT_EN
        if (!at_max) edge_cnt <= edge_cnt + CNT_W'(1);
`else
        edge_cnt <= edge_cnt + CNT_W'(1);
`endif
      end
    end
  func_seq_det u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .match    (match)
  );
endmodule
